mac_accumulator: RTL and testbench

Sequential accumulator that sits directly downstream of the N-bit combinational multiplier. It consumes one 2N-bit product per accepted beat and sums LEN products into a dot-product result. It supports unsigned and two's-complement modes, saturates on overflow, and presents each result through a valid/ready output handshake.

---
 rtl/mac_accumulator.sv | 128 ++++++++++++
 tb/tb_mac_accumulator.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/mac_accumulator.sv
// mac_accumulator: saturating dot-product accumulator fed by an
// N-bit multiplier; sums LEN products and offers each result by valid/ready.
module mac_accumulator #(
  parameter int N     = 4,
  parameter int ACC_W = 12,
  parameter int LEN   = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [2*N-1:0]             prod,
  input  logic                       is_signed,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ACC_W-1:0]           result,
  output logic                       ovf,
  output logic [$clog2(LEN+1)-1:0]   count
);

  localparam int PW  = 2 * N;
  localparam int CW  = $clog2(LEN + 1);
  localparam int EXT = ACC_W + 1 - PW;

  localparam logic [CW-1:0]    LAST = CW'(LEN - 1);
  localparam logic [ACC_W-1:0] UMAX = '1;
  localparam logic [ACC_W-1:0] SMAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic [ACC_W-1:0] SMIN = {1'b1, {(ACC_W-1){1'b0}}};

  typedef enum logic {ACCUM, HOLD} state_e;

  state_e             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [ACC_W-1:0]   res_q, res_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic               mode_q, mode_d;

  logic               mode_eff;
  logic [ACC_W:0]     acc_x;
  logic [ACC_W:0]     prod_x;
  logic [ACC_W:0]     sum;
  logic [ACC_W-1:0]   sat;
  logic               ov;

  // The group's mode is taken from the beat that opens it.
  always_comb begin
    mode_eff = (cnt_q == '0) ? is_signed : mode_q;
    prod_x   = {{EXT{mode_eff & prod[PW-1]}}, prod};
    acc_x    = {mode_eff & acc_q[ACC_W-1], acc_q};
    sum      = acc_x + prod_x;
    ov       = 1'b0;
    sat      = sum[ACC_W-1:0];
    if (mode_eff) begin
      ov = sum[ACC_W] ^ sum[ACC_W-1];
      if (ov) sat = sum[ACC_W] ? SMIN : SMAX;
    end else begin
      ov = sum[ACC_W];
      if (ov) sat = UMAX;
    end
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    res_d   = res_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    mode_d  = mode_q;
    if (clear) begin
      state_d = ACCUM;
      acc_d   = '0;
      cnt_d   = '0;
      ovf_d   = 1'b0;
      mode_d  = 1'b0;
    end else begin
      unique case (state_q)
        ACCUM: begin
          if (in_valid) begin
            mode_d = mode_eff;
            acc_d  = sat;
            ovf_d  = ovf_q | ov;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
              state_d = HOLD;
              res_d   = sat;
            end
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = ACCUM;
            acc_d   = '0;
            cnt_d   = '0;
            ovf_d   = 1'b0;
          end
        end
        default: state_d = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ACCUM;
      acc_q   <= '0;
      res_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      mode_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      mode_q  <= mode_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign out_valid = (state_q == HOLD);
  assign result    = res_q;
  assign ovf       = ovf_q;
  assign count     = cnt_q;

endmodule

// File: tb/tb_mac_accumulator.sv
// tb_mac_accumulator: directed vectors for the default build and an
// 8-bit, three-product build that exercises saturation.
module tb_mac_accumulator;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        a_clear, a_iv, a_ir, a_sg, a_ov, a_or, a_ovf;
  logic [7:0]  a_prod;
  logic [11:0] a_res;
  logic [2:0]  a_cnt;

  logic        b_clear, b_iv, b_ir, b_sg, b_ov, b_or, b_ovf;
  logic [7:0]  b_prod;
  logic [7:0]  b_res;
  logic [1:0]  b_cnt;

  int n_chk = 0;
  int n_err = 0;

  mac_accumulator #(.N(4), .ACC_W(12), .LEN(4)) u_a (
    .clk(clk), .rst_n(rst_n), .clear(a_clear),
    .in_valid(a_iv), .in_ready(a_ir), .prod(a_prod),
    .is_signed(a_sg), .out_valid(a_ov), .out_ready(a_or),
    .result(a_res), .ovf(a_ovf), .count(a_cnt)
  );

  mac_accumulator #(.N(4), .ACC_W(8), .LEN(3)) u_b (
    .clk(clk), .rst_n(rst_n), .clear(b_clear),
    .in_valid(b_iv), .in_ready(b_ir), .prod(b_prod),
    .is_signed(b_sg), .out_valid(b_ov), .out_ready(b_or),
    .result(b_res), .ovf(b_ovf), .count(b_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic abeat(input logic [7:0] p, input logic s);
    a_iv = 1'b1; a_prod = p; a_sg = s;
    tick();
    a_iv = 1'b0;
  endtask

  task automatic bbeat(input logic [7:0] p, input logic s);
    b_iv = 1'b1; b_prod = p; b_sg = s;
    tick();
    b_iv = 1'b0;
  endtask

  task automatic bgroup(input logic [7:0] p0, input logic [7:0] p1,
                        input logic [7:0] p2, input logic s,
                        input logic [7:0] er, input logic eo,
                        input string tag);
    bbeat(p0, s);
    bbeat(p1, s);
    bbeat(p2, s);
    chk({tag, "_valid"}, b_ov, 1);
    chk({tag, "_res"}, b_res, er);
    chk({tag, "_ovf"}, b_ovf, eo);
    tick();
    chk({tag, "_done"}, b_ov, 0);
  endtask

  initial begin
    a_clear = 0; a_iv = 0; a_sg = 0; a_or = 1; a_prod = '0;
    b_clear = 0; b_iv = 0; b_sg = 0; b_or = 1; b_prod = '0;
    #12;
    chk("rst_valid", a_ov, 0);
    chk("rst_res", a_res, 0);
    chk("rst_ovf", a_ovf, 0);
    chk("rst_cnt", a_cnt, 0);
    rst_n = 1'b1;
    tick();
    chk("rst_ready", a_ir, 1);

    // unsigned 4 x 225
    for (int i = 0; i < 4; i++) begin
      chk("u_cnt", a_cnt, 32'(i));
      abeat(8'd225, 1'b0);
    end
    chk("u_cnt4", a_cnt, 4);
    chk("u_valid", a_ov, 1);
    chk("u_ready", a_ir, 0);
    chk("u_res", a_res, 12'h384);
    chk("u_ovf", a_ovf, 0);
    tick();
    chk("u_hs_valid", a_ov, 0);
    chk("u_hs_cnt", a_cnt, 0);

    // signed 4 x -56
    for (int i = 0; i < 4; i++) abeat(8'hC8, 1'b1);
    chk("s_res", a_res, 12'hF20);
    chk("s_ovf", a_ovf, 0);
    tick();
    abeat(8'hC8, 1'b1);
    for (int i = 0; i < 3; i++) abeat(8'hC8, 1'b0);
    chk("s_mode_res", a_res, 12'hF20);
    tick();

    // backpressure
    a_or = 1'b0;
    for (int i = 0; i < 4; i++) abeat(8'd1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      a_iv = 1'b1; a_prod = 8'd100;
      tick();
      chk("bp_valid", a_ov, 1);
      chk("bp_ready", a_ir, 0);
      chk("bp_res", a_res, 4);
    end
    chk("bp_cnt", a_cnt, 4);
    a_iv = 1'b0; a_or = 1'b1;
    tick();
    chk("bp_hs_valid", a_ov, 0);
    chk("bp_hs_cnt", a_cnt, 0);
    for (int i = 0; i < 4; i++) abeat(8'd2, 1'b0);
    chk("bp_next_res", a_res, 8);
    tick();

    // clear mid-group and in HOLD
    abeat(8'd225, 1'b0);
    abeat(8'd225, 1'b0);
    chk("clr_pre_cnt", a_cnt, 2);
    a_clear = 1'b1; a_iv = 1'b1; a_prod = 8'd225;
    tick();
    a_clear = 1'b0; a_iv = 1'b0;
    chk("clr_cnt", a_cnt, 0);
    chk("clr_valid", a_ov, 0);
    for (int i = 0; i < 4; i++) abeat(8'd10, 1'b0);
    chk("clr_fresh_res", a_res, 40);
    chk("clr_hold_valid", a_ov, 1);
    a_clear = 1'b1; a_or = 1'b1;
    tick();
    a_clear = 1'b0;
    chk("clr_h_valid", a_ov, 0);
    chk("clr_h_cnt", a_cnt, 0);
    chk("clr_h_res", a_res, 40);

    // async reset mid-group
    for (int i = 0; i < 3; i++) abeat(8'd225, 1'b0);
    chk("ar_pre_cnt", a_cnt, 3);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_cnt", a_cnt, 0);
    chk("ar_res", a_res, 0);
    chk("ar_valid", a_ov, 0);
    chk("ar_ovf", a_ovf, 0);
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) abeat(8'd225, 1'b0);
    chk("ar_fresh_res", a_res, 12'h384);
    chk("ar_fresh_valid", a_ov, 1);
    tick();

    // saturation on 8-bit accumulator
    bgroup(8'd225, 8'd225, 8'd0, 1'b0, 8'hFF, 1'b1, "sat_u");
    bgroup(8'hC8, 8'h80, 8'd0, 1'b1, 8'h80, 1'b1, "sat_sn");
    bgroup(8'd127, 8'd127, 8'h80, 1'b1, 8'hFF, 1'b1, "sat_sp");
    bgroup(8'd100, 8'hCE, 8'd20, 1'b1, 8'd70, 1'b0, "nosat");

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
